// File: rtl/mont_modmul_ctrl.sv
// Sequencer for one Montgomery core: result = mont(mont(x, y), r2) = x*y mod n.
// Issues two core ops, guards each with a timeout, and rejects even moduli up front.
module mont_modmul_ctrl #(
    parameter int W       = 256,
    parameter int KW      = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  x,
    input  logic [W-1:0]  y,
    input  logic [W-1:0]  n,
    input  logic [W-1:0]  r2,
    input  logic [W-1:0]  s,
    input  logic [KW-1:0] k,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [W-1:0]  result,
    output logic [W-1:0]  mm_a,
    output logic [W-1:0]  mm_b,
    output logic [W-1:0]  mm_n,
    output logic [W-1:0]  mm_s,
    output logic [KW-1:0] mm_k,
    output logic          mm_start,
    input  logic [W-1:0]  mm_c,
    input  logic          mm_done
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ISSUE1 = 3'd1;
    localparam logic [2:0] WAIT1  = 3'd2;
    localparam logic [2:0] ISSUE2 = 3'd3;
    localparam logic [2:0] WAIT2  = 3'd4;
    localparam logic [2:0] FIN    = 3'd5;
    localparam logic [2:0] FAIL   = 3'd6;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [W-1:0]     r2_q;

    assign cnt_inc = cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            r2_q   <= '0;
            result <= '0;
            mm_a   <= '0;
            mm_b   <= '0;
            mm_n   <= '0;
            mm_s   <= '0;
            mm_k   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mm_n <= n;
                        mm_s <= s;
                        mm_k <= k;
                        r2_q <= r2;
                        if (n[0]) begin
                            mm_a  <= x;
                            mm_b  <= y;
                            state <= ISSUE1;
                        end else begin
                            state <= FAIL;
                        end
                    end
                end
                ISSUE1, ISSUE2: begin
                    cnt   <= '0;
                    state <= (state == ISSUE1) ? WAIT1 : WAIT2;
                end
                WAIT1, WAIT2: begin
                    // mm_done is only honoured here, so a stale done seen during ISSUE is dropped
                    if (mm_done) begin
                        if (state == WAIT1) begin
                            mm_a  <= mm_c;
                            mm_b  <= r2_q;
                            state <= ISSUE2;
                        end else begin
                            result <= mm_c;
                            state  <= FIN;
                        end
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            state <= FAIL;
                        end
                    end
                end
                FIN:     state <= IDLE;
                FAIL:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign mm_start = (state == ISSUE1) || (state == ISSUE2);
    assign done     = (state == FIN);
    assign err      = (state == FAIL);
    assign busy     = (state == ISSUE1) || (state == WAIT1) ||
                      (state == ISSUE2) || (state == WAIT2);

endmodule

// File: tb/tb_mont_modmul_ctrl.sv
// Bench for mont_modmul_ctrl: behavioural Montgomery core plus an x*y mod n reference,
// directed corner cases followed by randomized operations.
module tb_mont_modmul_ctrl;

    localparam int W  = 256;
    localparam int KW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  x, y, n, r2, s;
    logic [KW-1:0] k;
    logic          busy, done, err;
    logic [W-1:0]  result, mm_a, mm_b, mm_n, mm_s;
    logic [KW-1:0] mm_k;
    logic          mm_start;
    logic [W-1:0]  mm_c;
    logic          mm_done;

    mont_modmul_ctrl #(.W(W), .KW(KW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start),
        .x(x), .y(y), .n(n), .r2(r2), .s(s), .k(k),
        .busy(busy), .done(done), .err(err), .result(result),
        .mm_a(mm_a), .mm_b(mm_b), .mm_n(mm_n), .mm_s(mm_s), .mm_k(mm_k),
        .mm_start(mm_start), .mm_c(mm_c), .mm_done(mm_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ncmp  = 0;
    int nfail = 0;

    int            core_d   = 1;
    bit            core_en  = 1'b1;
    bit            stale_en = 1'b0;
    int            mm_start_cnt = 0;
    logic [W-1:0]  cap_n, cap_s;
    logic [KW-1:0] cap_k;

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Behavioural core: a*b*2^-W mod m by W halving steps.
    function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] m);
        logic [3*W-1:0] aa, bb, mm, p;
        aa = {{(2*W){1'b0}}, a};
        bb = {{(2*W){1'b0}}, b};
        mm = {{(2*W){1'b0}}, m};
        p  = aa * bb;
        for (int i = 0; i < W; i++) begin
            if (p[0]) p = p + mm;
            p = p >> 1;
        end
        if (p >= mm) p = p - mm;
        return p[W-1:0];
    endfunction

    // Reference: plain modular product.
    function automatic logic [W-1:0] modmul(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] m);
        logic [2*W-1:0] aa, bb, mm, r;
        aa = {{W{1'b0}}, a};
        bb = {{W{1'b0}}, b};
        mm = {{W{1'b0}}, m};
        r  = (aa * bb) % mm;
        return r[W-1:0];
    endfunction

    function automatic logic [W-1:0] r2_of(input logic [W-1:0] m);
        logic [3*W-1:0] one, mm, r;
        one = 1;
        one = one << (2 * W);
        mm  = {{(2*W){1'b0}}, m};
        r   = one % mm;
        return r[W-1:0];
    endfunction

    // Core model: answers D cycles after each mm_start; may also fake a stale done.
    initial begin
        int cd;
        logic [W-1:0] pend;
        cd = 0;
        pend = '0;
        mm_done = 1'b0;
        mm_c = '0;
        forever begin
            @(negedge clk);
            mm_done = 1'b0;
            if (reset) begin
                cd = 0;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    mm_done = 1'b1;
                    mm_c = pend;
                end
            end
            if (mm_start) begin
                mm_start_cnt++;
                cap_n = mm_n;
                cap_s = mm_s;
                cap_k = mm_k;
                if (core_en) begin
                    cd = core_d;
                    pend = mont(mm_a, mm_b, mm_n);
                    if (stale_en) begin
                        mm_done = 1'b1;
                        mm_c = rand_w();
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs();
        chk_i("rst_busy", int'(busy), 0);
        chk_i("rst_done", int'(done), 0);
        chk_i("rst_err", int'(err), 0);
        chk_i("rst_mm_start", int'(mm_start), 0);
        chk("rst_result", result, '0);
        chk("rst_mm_a", mm_a, '0);
        chk("rst_mm_b", mm_b, '0);
        chk("rst_mm_n", mm_n, '0);
        chk("rst_mm_s", mm_s, '0);
        chk_i("rst_mm_k", int'(mm_k), 0);
    endtask

    // Waits (bounded) for done or err, starting with the current cycle.
    task automatic wait_end(input int t0, output int lat, output bit e);
        lat = -1;
        e = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done || err) begin
                lat = cyc - t0;
                e = err;
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) begin
            chk_i("end_within_bound", int'(done | err), 1);
        end else begin
            chk_i("done_err_exclusive", int'(done & err), 0);
            chk_i("busy_low_at_end", int'(busy), 0);
        end
    endtask

    task automatic run_op(input logic [W-1:0] ix, input logic [W-1:0] iy, input logic [W-1:0] in_,
                          input logic [W-1:0] ir2, input logic [W-1:0] is, input logic [KW-1:0] ik,
                          input int d, output int lat, output bit e, output int ns);
        int t0, s0;
        @(negedge clk);
        x = ix; y = iy; n = in_; r2 = ir2; s = is; k = ik;
        core_d = d;
        start = 1'b1;
        t0 = cyc;
        s0 = mm_start_cnt;
        @(negedge clk);
        start = 1'b0;
        // inputs must have been captured at start; scramble them for the rest of the op
        x = rand_w(); y = rand_w(); n = rand_w(); r2 = rand_w(); s = rand_w(); k = KW'($urandom);
        wait_end(t0, lat, e);
        ns = mm_start_cnt - s0;
    endtask

    initial begin
        logic [W-1:0]  tx, ty, tn, tr2, ts, exp_res, last_res;
        logic [KW-1:0] tk;
        int lat, ns, d, t0, s0;
        bit e, bad;

        reset = 1'b1; start = 1'b0;
        x = '0; y = '0; n = '0; r2 = '0; s = '0; k = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;

        // Directed reference case, D=5
        tx = 357588; ty = 543191; tn = 10000019; tr2 = r2_of(tn);
        ts = rand_w(); tk = KW'($urandom);
        run_op(tx, ty, tn, tr2, ts, tk, 5, lat, e, ns);
        chk("d5_result_const", result, 8214271);
        chk("d5_result_model", result, modmul(tx, ty, tn));
        chk_i("d5_latency", lat, 13);
        chk_i("d5_err", int'(e), 0);
        chk_i("d5_mm_start_count", ns, 2);
        chk("d5_mm_n", cap_n, tn);
        chk("d5_mm_s", cap_s, ts);
        chk_i("d5_mm_k", int'(cap_k), int'(tk));

        // Same op, D=1
        run_op(tx, ty, tn, tr2, ts, tk, 1, lat, e, ns);
        chk("d1_result", result, 8214271);
        chk_i("d1_latency", lat, 5);
        chk_i("d1_mm_start_count", ns, 2);
        last_res = result;

        // Even modulus
        run_op(tx, ty, 10000018, tr2, ts, tk, 1, lat, e, ns);
        chk_i("even_err", int'(e), 1);
        chk_i("even_latency", lat, 1);
        chk_i("even_mm_start_count", ns, 0);
        chk("even_result_held", result, last_res);

        // Core never answers
        core_en = 1'b0;
        tn = rand_w() | 1; tx = rand_w() % tn; ty = rand_w() % tn;
        run_op(tx, ty, tn, r2_of(tn), rand_w(), KW'($urandom), 1, lat, e, ns);
        chk_i("timeout_err", int'(e), 1);
        chk_i("timeout_latency", lat, TO + 2);
        chk_i("timeout_mm_start_count", ns, 1);
        chk("timeout_result_held", result, last_res);
        core_en = 1'b1;

        // Core answers in the last allowed wait cycle
        tn = rand_w() | 1; tx = rand_w() % tn; ty = rand_w() % tn;
        run_op(tx, ty, tn, r2_of(tn), rand_w(), KW'($urandom), TO, lat, e, ns);
        chk_i("edge_d16_err", int'(e), 0);
        chk_i("edge_d16_latency", lat, 2 * TO + 3);
        chk("edge_d16_result", result, modmul(tx, ty, tn));

        // Reset while waiting on the second core op
        tn = rand_w() | 1; tx = rand_w() % tn; ty = rand_w() % tn;
        @(negedge clk);
        x = tx; y = ty; n = tn; r2 = r2_of(tn); s = rand_w(); k = KW'($urandom);
        core_d = 5; start = 1'b1; t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t0 + 9) @(negedge clk);
        chk_i("wait2_busy", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;
        bad = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done || err) bad = 1'b1;
        end
        chk_i("no_end_after_reset", int'(bad), 0);
        run_op(tx, ty, tn, r2_of(tn), rand_w(), KW'($urandom), 3, lat, e, ns);
        chk("after_reset_result", result, modmul(tx, ty, tn));
        chk_i("after_reset_latency", lat, 9);

        // start held high: exactly one op, then a second one right after done
        tn = rand_w() | 1; tx = rand_w() % tn; ty = rand_w() % tn;
        exp_res = modmul(tx, ty, tn);
        @(negedge clk);
        x = tx; y = ty; n = tn; r2 = r2_of(tn); s = rand_w(); k = KW'($urandom);
        core_d = 2; start = 1'b1; t0 = cyc; s0 = mm_start_cnt;
        @(negedge clk);
        wait_end(t0, lat, e);
        chk_i("hold_first_latency", lat, 7);
        chk("hold_first_result", result, exp_res);
        @(negedge clk);
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        chk_i("hold_second_busy", int'(busy), 1);
        chk_i("hold_second_mm_start", int'(mm_start), 1);
        wait_end(t0, lat, e);
        chk_i("hold_second_latency", lat, 7);
        chk("hold_second_result", result, exp_res);
        chk_i("hold_mm_start_count", mm_start_cnt - s0, 4);

        // Stale done during ISSUE cycles
        stale_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            d = (i == 0) ? 1 : 4;
            tn = rand_w() | 1; tx = rand_w() % tn; ty = rand_w() % tn;
            run_op(tx, ty, tn, r2_of(tn), rand_w(), KW'($urandom), d, lat, e, ns);
            chk("stale_result", result, modmul(tx, ty, tn));
            chk_i("stale_latency", lat, 2 * d + 3);
        end
        stale_en = 1'b0;

        // Randomized operations
        for (int i = 0; i < 6; i++) begin
            d = $urandom_range(1, 6);
            tn = rand_w() | 1; tx = rand_w() % tn; ty = rand_w() % tn;
            ts = rand_w(); tk = KW'($urandom);
            run_op(tx, ty, tn, r2_of(tn), ts, tk, d, lat, e, ns);
            chk("rand_result", result, modmul(tx, ty, tn));
            chk_i("rand_latency", lat, 2 * d + 3);
            chk_i("rand_mm_start_count", ns, 2);
            chk("rand_mm_s", cap_s, ts);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
